nibble_serial_adder: RTL and testbench
======================================

# nibble_serial_adder

Sequential N-bit adder controller that reuses one 4-bit carry-lookahead slice (`cla`) over multiple cycles. Operands are latched on a start handshake, one nibble is processed per clock from LSB to MSB, and the carry is registered between slices. This trades latency for area in datapaths where a full-width CLA is not warranted. It is the sequencing block around the existing 4-bit CLA datapath.

## Interface
- `WIDTH`, default 16: operand width in bits. Must be a multiple of 4 and at least 8.
- `clk` input, 1: single clock, rising edge.
- `rst` input, 1: synchronous, active-high reset.
- `start` input, 1: request to begin an addition. Sampled only when the block is accepting (see below).
- `a` input, WIDTH: operand A. Sampled on the accepting edge.
- `b` input, WIDTH: operand B. Sampled on the accepting edge.
- `cin` input, 1: carry-in. Sampled on the accepting edge.
- `busy` output, 1: high while nibbles are being processed.
- `done` output, 1: one-cycle pulse marking `sum`/`cout` valid.
- `sum` output, WIDTH: result. Held until the next accepted start.
- `cout` output, 1: carry-out of the MSB nibble.

## Operation
- NIB = WIDTH/4. Internal state:
  - operand registers `a_q`, `b_q`;
  - carry register `c_q`;
  - nibble index `idx`, width clog2(NIB);
  - result register.
- FSM states are IDLE, ADD and DONE.
  - IDLE: if `start`, latch `a`, `b`, `cin` into `a_q`, `b_q`, `c_q`. Set `idx` to 0, set `sum` to 0, go to ADD.
  - ADD, every cycle:
    - Drive the `cla` slice with `a_q[4*idx+:4]`, `b_q[4*idx+:4]` and carry-in `c_q`.
    - Write the slice sum into `sum[4*idx+:4]`.
    - Set `c_q` to the slice carry-out, bit [4] of its 5-bit carry vector.
    - If `idx`==NIB-1: set `cout` to the slice carry-out and go to DONE. Otherwise increment `idx`.
  - DONE: `done`=1 for exactly this cycle.
    - If `start` is high, accept as in IDLE and go to ADD (back-to-back operation).
    - Otherwise go to IDLE.
- Accepting states are IDLE and DONE. `start` in ADD is ignored: the operation is not queued and the operands are not resampled.
- Arithmetic is unsigned. The full result is {`cout`,`sum`} = `a`+`b`+`cin`, taken modulo 2^(WIDTH+1). No overflow flag.
- Reset, asserted in any state including mid-ADD:
  - next state is IDLE;
  - `busy`=0, `done`=0, `sum`=0, `cout`=0;
  - `idx`=0, `c_q`=0;
  - any partial result is discarded.
- Reset has priority over `start` on the same edge.

## Timing
- All outputs are registered. Reset values: `busy`=0, `done`=0, `sum`=0, `cout`=0.
- Let edge E0 be the accepting edge.
  - `busy` rises after E0.
  - Nibble k is written on edge E(k+1), for k = 0..NIB-1.
  - On edge E(NIB), `busy` falls and `done` rises together.
- Latency is NIB cycles from accept to `done`. For WIDTH=16 that is 4 cycles.
- Back-to-back throughput is one result per NIB+1 cycles. `start` is held high continuously in that case.
- `sum` and `cout` are stable from `done` until the edge after the next accept, at which point they are cleared.
- `sum` nibbles above `idx` read 0 while `busy` is high.

## Structure
- One sub-module, `cla`: the existing 4-bit CLA slice.
  - Ports: `a[3:0]`, `b[3:0]`, `cin`, `sum[3:0]`, `cout[4:0]`.
  - `cout[4]` is the carry-out.
  - It is instantiated once and is purely combinational.
- Shared package `adder_pkg` holds:
  - the FSM state encoding (IDLE, ADD, DONE) as a 2-bit enum;
  - the slice width constant SLICE_W = 4.
- NIB and the `idx` width are derived locally from WIDTH.

## Test plan
- Reset, then add 0x0000+0x0000 with `cin`=0. Expect `done` 4 cycles after accept, `sum`=0x0000, `cout`=0, and `busy` high for exactly 4 cycles.
- Add 0xFFFF+0x0001 with `cin`=0. Expect `sum`=0x0000, `cout`=1: the carry propagates through all four nibbles via `c_q`.
- Add 0x1234+0x4321 with `cin`=1. Expect `sum`=0x5556, `cout`=0. Add 0xA5A5+0x5A5A with `cin`=1. Expect `sum`=0x0000, `cout`=1.
- Pulse `start` with 0x0F0F+0x0101 and `cin`=0.
  - Two cycles later, with `busy` high, pulse `start` again with 0xFFFF+0xFFFF.
  - Expect the second `start` to be ignored: a single `done` with `sum`=0x1010, `cout`=0.
- Hold `start` high across two operations, 0x0006+0x000B and then 0x000F+0x0001, both with `cin`=0.
  - Expect the first `done` with `sum`=0x0011, immediately followed by the second operation starting.
  - Expect the second `done` 5 cycles after the first, with `sum`=0x0010.
- Assert `rst` for one cycle while `idx`=2 in ADD.
  - Expect `busy`=0, `done`=0, `sum`=0, `cout`=0 on the next cycle, and no `done` pulse afterwards.
  - Then add 0x0001+0x0001 with `cin`=0. Expect `sum`=0x0002.

Source files
------------

// File: rtl/adder_pkg.sv
// Shared definitions for the nibble-serial adder: controller state encoding
// and the width of the reused carry-lookahead slice.
package adder_pkg;

  localparam int SLICE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/nibble_serial_adder_cla.sv
// Purely combinational 4-bit carry-lookahead slice; cout[i] is the carry into
// bit i, so cout[4] is the slice carry-out.
module cla
  import adder_pkg::*;
(
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               cin,
  output logic [SLICE_W-1:0] sum,
  output logic [SLICE_W:0]   cout
);

  logic [SLICE_W-1:0] g;
  logic [SLICE_W-1:0] p;

  assign g = a & b;
  assign p = a ^ b;

  // Every carry is expanded from generate/propagate terms rather than rippled.
  assign cout[0] = cin;
  assign cout[1] = g[0] | (p[0] & cin);
  assign cout[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
  assign cout[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                 | (p[2] & p[1] & p[0] & cin);
  assign cout[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                 | (p[3] & p[2] & p[1] & g[0])
                 | (p[3] & p[2] & p[1] & p[0] & cin);

  assign sum = p ^ cout[SLICE_W-1:0];

endmodule

// File: rtl/nibble_serial_adder.sv
// Sequential WIDTH-bit adder that walks one shared 4-bit CLA slice across the
// operands, LSB nibble first, carrying between nibbles through c_q.
module nibble_serial_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int NIB   = WIDTH / SLICE_W;
  localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIB - 1);

  if ((WIDTH % SLICE_W) != 0 || WIDTH < 8) begin : g_width_check
    $error("nibble_serial_adder: WIDTH must be a multiple of 4 and at least 8");
  end

  state_t             state;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic               c_q;
  logic [IDX_W-1:0]   idx;

  logic [SLICE_W-1:0] slice_a;
  logic [SLICE_W-1:0] slice_b;
  logic [SLICE_W-1:0] slice_sum;
  logic [SLICE_W:0]   slice_carry;
  logic               unused_carry;

  assign slice_a = a_q[SLICE_W*idx +: SLICE_W];
  assign slice_b = b_q[SLICE_W*idx +: SLICE_W];

  // Only the slice carry-out feeds back; the internal carries are not needed here.
  assign unused_carry = ^slice_carry[SLICE_W-1:0];

  cla u_cla (
    .a    (slice_a),
    .b    (slice_b),
    .cin  (c_q),
    .sum  (slice_sum),
    .cout (slice_carry)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
      idx   <= '0;
      c_q   <= 1'b0;
      a_q   <= '0;
      b_q   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        // DONE accepts exactly like IDLE so start held high gives back-to-back runs.
        IDLE, DONE: begin
          if (start) begin
            a_q   <= a;
            b_q   <= b;
            c_q   <= cin;
            idx   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
            busy  <= 1'b1;
            state <= ADD;
          end else begin
            state <= IDLE;
          end
        end
        ADD: begin
          sum[SLICE_W*idx +: SLICE_W] <= slice_sum;
          c_q <= slice_carry[SLICE_W];
          if (idx == LAST_IDX) begin
            cout  <= slice_carry[SLICE_W];
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Directed bench for the 16-bit nibble-serial adder: a table of additions plus
// hand-written sequences for ignored start, back-to-back and mid-run reset.
module tb_nibble_serial_adder;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] a;
  logic [15:0] b;
  logic        cin;
  logic        busy;
  logic        done;
  logic [15:0] sum;
  logic        cout;

  int passed = 0;
  int total  = 0;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic [15:0] exp_sum;
    logic        exp_cout;
  } vec_t;

  nibble_serial_adder #(.WIDTH(16)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Drives one start pulse and follows the run to its done pulse (bounded).
  task automatic apply_stimulus(input logic [15:0] va, input logic [15:0] vb,
                                input logic vc, output int lat,
                                output int busy_cyc, output int upper_bad);
    logic [31:0] mask;
    lat = -1;
    busy_cyc = 0;
    upper_bad = 0;
    @(negedge clk);
    a = va;
    b = vb;
    cin = vc;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (done) begin
        lat = i - 1;
        break;
      end
      if (busy) busy_cyc++;
      mask = (32'h1 << (4 * (i - 1))) - 32'h1;
      if ((sum & ~mask[15:0]) != 16'h0) upper_bad++;
    end
  endtask

  initial begin
    vec_t vecs[7];
    int   lat;
    int   bcyc;
    int   ubad;
    int   extra;
    int   found;

    vecs[0] = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0};
    vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1};
    vecs[2] = '{16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0};
    vecs[3] = '{16'hA5A5, 16'h5A5A, 1'b1, 16'h0000, 1'b1};
    vecs[4] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1};
    vecs[5] = '{16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0};
    vecs[6] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1};

    // Reset with start held high: reset must win.
    rst = 1'b1;
    start = 1'b1;
    a = 16'h1111;
    b = 16'h2222;
    cin = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_output("reset_busy", 32'(busy), 32'h0);
    check_output("reset_done", 32'(done), 32'h0);
    check_output("reset_sum", 32'(sum), 32'h0);
    check_output("reset_cout", 32'(cout), 32'h0);
    start = 1'b0;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check_output("idle_busy", 32'(busy), 32'h0);

    for (int v = 0; v < 7; v++) begin
      apply_stimulus(vecs[v].a, vecs[v].b, vecs[v].cin, lat, bcyc, ubad);
      check_output($sformatf("vec%0d_latency", v), 32'(lat), 32'd4);
      check_output($sformatf("vec%0d_busy_cycles", v), 32'(bcyc), 32'd4);
      check_output($sformatf("vec%0d_upper_zero", v), 32'(ubad), 32'd0);
      check_output($sformatf("vec%0d_busy_at_done", v), 32'(busy), 32'h0);
      check_output($sformatf("vec%0d_sum", v), 32'(sum), 32'(vecs[v].exp_sum));
      check_output($sformatf("vec%0d_cout", v), 32'(cout), 32'(vecs[v].exp_cout));
      @(negedge clk);
      check_output($sformatf("vec%0d_done_pulse", v), 32'(done), 32'h0);
      check_output($sformatf("vec%0d_sum_held", v), 32'(sum), 32'(vecs[v].exp_sum));
    end

    // Start during ADD must be ignored.
    @(negedge clk);
    a = 16'h0F0F;
    b = 16'h0101;
    cin = 1'b0;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (2) @(negedge clk);
    check_output("ignore_busy", 32'(busy), 32'h1);
    a = 16'hFFFF;
    b = 16'hFFFF;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    found = -1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (done) begin
        found = i;
        break;
      end
    end
    check_output("ignore_done_time", 32'(found), 32'd3);
    check_output("ignore_sum", 32'(sum), 32'h1010);
    check_output("ignore_cout", 32'(cout), 32'h0);
    extra = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done || busy) extra++;
    end
    check_output("ignore_no_second_run", 32'(extra), 32'h0);

    // Back-to-back with start held high.
    @(negedge clk);
    a = 16'h0006;
    b = 16'h000B;
    cin = 1'b0;
    start = 1'b1;
    @(posedge clk);
    #1;
    a = 16'h000F;
    b = 16'h0001;
    found = -1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (done) begin
        found = i - 1;
        break;
      end
    end
    check_output("b2b_first_latency", 32'(found), 32'd4);
    check_output("b2b_first_sum", 32'(sum), 32'h0011);
    check_output("b2b_first_cout", 32'(cout), 32'h0);
    found = -1;
    for (int j = 1; j <= 20; j++) begin
      @(negedge clk);
      if (j == 1) check_output("b2b_restart_busy", 32'(busy), 32'h1);
      if (done) begin
        found = j;
        break;
      end
    end
    start = 1'b0;
    check_output("b2b_second_spacing", 32'(found), 32'd5);
    check_output("b2b_second_sum", 32'(sum), 32'h0010);
    check_output("b2b_second_cout", 32'(cout), 32'h0);

    // Reset while idx == 2 in ADD.
    repeat (2) @(negedge clk);
    a = 16'h1234;
    b = 16'h1111;
    cin = 1'b0;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(negedge clk);
    check_output("midrst_busy_before", 32'(busy), 32'h1);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_output("midrst_busy", 32'(busy), 32'h0);
    check_output("midrst_done", 32'(done), 32'h0);
    check_output("midrst_sum", 32'(sum), 32'h0);
    check_output("midrst_cout", 32'(cout), 32'h0);
    extra = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done || busy) extra++;
    end
    check_output("midrst_no_done", 32'(extra), 32'h0);
    apply_stimulus(16'h0001, 16'h0001, 1'b0, lat, bcyc, ubad);
    check_output("post_rst_latency", 32'(lat), 32'd4);
    check_output("post_rst_sum", 32'(sum), 32'h0002);
    check_output("post_rst_cout", 32'(cout), 32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
